// File: rtl/fetch_pkg.sv
// Shared types and constants for the IF-stage fetch controller.
// State encoding, halt word and sequential PC step.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    localparam logic [31:0] INSN_HALT = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/fetch_controller_pc_range_check.sv
// Legal-target check for instruction addresses.
// A PC is legal when word aligned and inside instruction memory.
module pc_range_check #(
    parameter int IMEM_DEPTH = 1024
) (
    input  logic [31:0] pc,
    output logic        ok
);

    localparam logic [32:0] LIMIT = 33'(4 * IMEM_DEPTH);

    assign ok = (pc[1:0] == 2'b00) && ({1'b0, pc} < LIMIT);

endmodule

// File: rtl/fetch_controller.sv
// IF-stage sequencer for the 1-cycle-latency instruction memory.
// Handles stall replay, redirect flush, halt word and address faults.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_DEPTH = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instruction,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instruction,
    output logic        halted,
    output logic        fault,
    output logic [31:0] fetch_count
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         vld_q, vld_d;
    logic         fault_set;
    logic [31:0]  seq_pc;
    logic         redir_ok;
    logic         seq_ok;

    assign seq_pc = pc_q + PC_STEP;

    pc_range_check #(.IMEM_DEPTH(IMEM_DEPTH)) u_redir_chk (
        .pc (redirect_pc),
        .ok (redir_ok)
    );

    pc_range_check #(.IMEM_DEPTH(IMEM_DEPTH)) u_seq_chk (
        .pc (seq_pc),
        .ok (seq_ok)
    );

    assign if_pc          = pc_q;
    assign if_instruction = imem_instruction;
    assign halted         = !reset && (state_q == HALT);
    assign if_valid       = !reset && vld_q && (state_q == RUN)
                            && !redirect_valid
                            && (imem_instruction != INSN_HALT);

    // Next fetch address and next-state selection.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        vld_d     = vld_q;
        fault_set = 1'b0;
        imem_pc   = pc_q;
        unique case (state_q)
            BOOT: begin
                state_d = RUN;
                vld_d   = 1'b1;
            end
            RUN: begin
                if (redirect_valid) begin
                    if (redir_ok) begin
                        imem_pc = redirect_pc;
                        pc_d    = redirect_pc;
                        vld_d   = 1'b1;
                    end else begin
                        fault_set = 1'b1;
                        state_d   = HALT;
                    end
                end else if (stall) begin
                    imem_pc = pc_q;
                end else if (vld_q && imem_instruction == INSN_HALT) begin
                    state_d = HALT;
                end else if (seq_ok) begin
                    imem_pc = seq_pc;
                    pc_d    = seq_pc;
                    vld_d   = 1'b1;
                end else begin
                    fault_set = 1'b1;
                    state_d   = HALT;
                end
            end
            HALT: begin
                if (redirect_valid) begin
                    if (redir_ok) begin
                        imem_pc = redirect_pc;
                        pc_d    = redirect_pc;
                        vld_d   = 1'b1;
                        state_d = RUN;
                    end else begin
                        fault_set = 1'b1;
                    end
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
        if (reset) begin
            imem_pc = RESET_PC;
        end
    end

    // State, PC, sticky fault and accepted-instruction counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= BOOT;
            pc_q        <= RESET_PC;
            vld_q       <= 1'b0;
            fault       <= 1'b0;
            fetch_count <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            vld_q   <= vld_d;
            if (fault_set) begin
                fault <= 1'b1;
            end
            if (if_valid && !stall) begin
                fetch_count <= fetch_count + 32'd1;
            end
        end
    end

endmodule
